// File: rtl/pwm_fade_pkg.sv
// Shared types and default widths for the PWM fade controller.
package pwm_fade_pkg;

    localparam int unsigned DefDutyW = 8;
    localparam int unsigned DefIvlW  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRamp,
        StDone
    } fade_state_e;

endpackage

// File: rtl/fade_tick_gen.sv
// Step-interval down-counter: loads on request accept, reloads and pulses expire at zero.
module fade_tick_gen #(
    parameter int unsigned IVL_W = pwm_fade_pkg::DefIvlW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IVL_W-1:0] load_val,
    input  logic             run,
    input  logic [IVL_W-1:0] reload_val,
    output logic             expire
);

    logic [IVL_W-1:0] count_q;
    logic [IVL_W-1:0] count_d;

    assign expire = run && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (run) begin
            count_d = (count_q == '0) ? reload_val : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade controller: ramps a registered PWM duty value toward a target in timed steps.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int unsigned DUTY_W = DefDutyW,
    parameter int unsigned IVL_W  = DefIvlW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DUTY_W-1:0] cfg_target,
    input  logic [3:0]        cfg_step,
    input  logic [IVL_W-1:0]  cfg_interval,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    fade_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [3:0]        step_q, step_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;

    logic              accept;
    logic              tick;
    logic [DUTY_W:0]   tgt_x, duty_x, step_x, diff, stepped;
    logic [DUTY_W-1:0] duty_step;

    assign cfg_ready = (state_q == StIdle) && !abort;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state_q != StIdle);
    // An abort landing in the DONE cycle suppresses the completion pulse.
    assign done      = (state_q == StDone) && !abort;
    assign duty_out  = duty_q;

    fade_tick_gen #(
        .IVL_W (IVL_W)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_val   (cfg_interval),
        .run        (state_q == StRamp),
        .reload_val (ivl_q),
        .expire     (tick)
    );

    // One step toward target, one bit wider so neither direction can wrap.
    always_comb begin
        tgt_x   = {1'b0, target_q};
        duty_x  = {1'b0, duty_q};
        step_x  = {{(DUTY_W - 3){1'b0}}, step_q};
        diff    = '0;
        stepped = '0;
        if (tgt_x >= duty_x) begin
            diff    = tgt_x - duty_x;
            stepped = duty_x + step_x;
        end else begin
            diff    = duty_x - tgt_x;
            stepped = duty_x - step_x;
        end
        duty_step = (diff <= step_x) ? target_q : stepped[DUTY_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        ivl_d    = ivl_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StRamp;
                    target_d = cfg_target;
                    step_d   = (cfg_step == 4'd0) ? 4'd1 : cfg_step;
                    ivl_d    = cfg_interval;
                end
            end
            StRamp: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (tick) begin
                    duty_d = duty_step;
                    if (duty_step == target_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            ivl_q    <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            ivl_q    <= ivl_d;
        end
    end

endmodule
